// File: rtl/sel_pipe_mux_pkg.sv
// rtl/sel_pipe_mux_pkg.sv - shared datapath constants for the select pipe mux
package sel_pipe_mux_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_NUM_IN = 4;

    // Occupancy of the main + skid register pair.
    localparam int         STATE_W = 2;
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] ONE     = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

endpackage

// File: rtl/sel_pipe_mux_pick.sv
// rtl/sel_pipe_mux_pick.sv - combinational NUM_IN-way select with out-of-range flag
module sel_pipe_mux_pick
    import sel_pipe_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // An index with no matching input yields zero data and raises err.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sel_pipe_mux.sv
// rtl/sel_pipe_mux.sv - registered select mux with skid buffer and valid/ready handshake
module sel_pipe_mux
    import sel_pipe_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    sel_pipe_mux_pick #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick (
        .in_data (in_data),
        .in_sel  (in_sel),
        .data    (pick_data),
        .err     (pick_err)
    );

    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            state    <= state_next;
            // Registered so in_ready never sees out_ready combinationally.
            in_ready <= (state_next != FULL);
            if (load_main_in) begin
                out_data <= pick_data;
                out_sel  <= in_sel;
                out_err  <= pick_err;
            end else if (load_main_skid) begin
                out_data <= skid_data;
                out_sel  <= skid_sel;
                out_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= pick_data;
                skid_sel  <= in_sel;
                skid_err  <= pick_err;
            end
        end
    end

endmodule

// File: tb/tb_sel_pipe_mux.sv
// tb/tb_sel_pipe_mux.sv - directed and randomized handshake checks for sel_pipe_mux
module tb_sel_pipe_mux;

    logic         clk = 1'b0;
    logic         rst;

    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_err3;
    logic         out_valid3;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sel_pipe_mux #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    sel_pipe_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (1'b1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int cycles;
        logic in_fire;
        logic out_fire;

        rst       = 1'b1;
        in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data3  = {32'h333, 32'h222, 32'h111};
        in_sel3   = 2'd0;
        in_valid3 = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_err", out_err, 0);

        // Streaming at full rate, first beat on the first edge out of reset.
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i);
            step();
            check($sformatf("stream_data%0d", i), out_data, 64'(32'h11 * (i + 1)));
            check($sformatf("stream_sel%0d", i), out_sel, 64'(i));
            check($sformatf("stream_valid%0d", i), out_valid, 1);
            check($sformatf("stream_ready%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_hold", out_data, 32'h44);

        // Backpressure fills the skid register.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        step();
        check("bp1_data", out_data, 32'h33);
        check("bp1_ready", in_ready, 1);
        in_sel = 2'd0;
        step();
        check("bp2_ready", in_ready, 0);
        check("bp2_data", out_data, 32'h33);
        in_valid = 1'b0;
        step();
        check("bp3_hold", out_data, 32'h33);
        check("bp3_sel", out_sel, 2);
        out_ready = 1'b1;
        step();
        check("bp4_data", out_data, 32'h11);
        check("bp4_ready", in_ready, 1);
        check("bp4_valid", out_valid, 1);
        step();
        check("bp5_valid", out_valid, 0);

        // Input changes with no transfer are ignored.
        in_data = {4{32'hDEAD_BEEF}};
        in_sel  = 2'd1;
        step();
        check("idle_data", out_data, 32'h11);
        check("idle_sel", out_sel, 0);
        check("idle_valid", out_valid, 0);
        in_data = {32'h44, 32'h33, 32'h22, 32'h11};

        // Reset from FULL discards both beats.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        step();
        in_sel = 2'd3;
        step();
        check("full_ready", in_ready, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        check("frst_valid", out_valid, 0);
        check("frst_ready", in_ready, 1);
        check("frst_data", out_data, 0);
        check("frst_sel", out_sel, 0);
        check("frst_err", out_err, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_data[31:0] = 32'hAA;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        step();
        check("post_rst_data", out_data, 32'hAA);
        check("post_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("post_rst_empty", out_valid, 0);
        step();
        check("post_rst_no_ghost", out_valid, 0);

        // Three-input instance: out-of-range select.
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        step();
        check("oor_data", out_data3, 0);
        check("oor_err", out_err3, 1);
        check("oor_sel", out_sel3, 3);
        in_sel3 = 2'd1;
        step();
        check("inr_data", out_data3, 32'h222);
        check("inr_err", out_err3, 0);
        in_valid3 = 1'b0;

        // Random valid/ready; each beat carries its sequence number.
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while (recv < 1000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 1) == 1) && (sent < 1000);
            out_ready = ($urandom_range(0, 1) == 1);
            in_sel    = 2'(sent % 4);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_data[(sent % 4)*32 +: 32] = 32'(sent);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                check("rand_data", out_data, 64'(recv));
                check("rand_sel", out_sel, 64'(recv % 4));
            end
            step();
            cycles++;
            if (in_fire) sent++;
            if (out_fire) recv++;
        end
        check("rand_count", recv, 1000);
        in_valid = 1'b0;
        step();
        check("rand_no_extra", out_valid, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
